ad7265_emu: RTL and testbench

- Synthesizable AD7265 responder (device emulator). It sits on the ADC side of the SPI-like bus: it takes adc_sclk, adc_ncs, adc_addr and adc_rng, and drives adc_a/adc_b serial data.
- Sample values come from a 6-entry host-written register file. The block is used for FPGA loopback self-test of the ADC controller path and for board bring-up without a populated ADC.
- All bus inputs are treated as asynchronous and are oversampled in the clk domain.

---
 rtl/ad7265_pkg.sv | 30 +++
 rtl/sync_edge_det.sv | 30 +++
 rtl/ad7265_emu.sv | 169 ++++++++++++++++
 tb/tb_ad7265_emu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ad7265_pkg.sv
// AD7265 responder: shared types, sizes and slot helper.
// Used by the emulator top and its bench.
package ad7265_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, TRAIL} state_t;

  localparam int N_CH   = 6;
  localparam int DATA_W = 12;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = 8;

  localparam int DEF_LEAD_ZEROS = 2;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_MIN_FALLS  = 14;

  // Bit shown in slot idx: lead zeros, then D11..D0, then zeros.
  function automatic logic slot_bit(
    input logic [DATA_W-1:0] d,
    input logic [IDX_W-1:0]  idx,
    input int                lead
  );
    int k;
    logic [DATA_W-1:0] t;
    k = int'(idx) - lead;
    t = d << k;
    if (k >= 0 && k < DATA_W) return t[DATA_W-1];
    return 1'b0;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with single-clk rise/fall pulses.
// RST_VAL sets the level the chain assumes during reset.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end

  assign rise = sr[STAGES-1] & ~prev;
  assign fall = ~sr[STAGES-1] & prev;

endmodule

// File: rtl/ad7265_emu.sv
// AD7265 device emulator: serves register-file samples on adc_a/adc_b
// framed by adc_ncs and clocked out on adc_sclk falling edges.
module ad7265_emu
  import ad7265_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LEAD_ZEROS     = DEF_LEAD_ZEROS,
  parameter int FRAME_BITS     = DEF_FRAME_BITS,
  parameter int MIN_SCLK_FALLS = DEF_MIN_FALLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_sclk,
  input  logic              adc_ncs,
  input  logic [2:0]        adc_addr,
  input  logic              adc_rng,
  output logic              adc_a,
  output logic              adc_b,
  output logic              adc_oe,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  output logic              conv_done,
  output logic [2:0]        conv_ch,
  output logic              conv_rng,
  output logic [15:0]       conv_count,
  output logic              addr_err,
  input  logic              err_clr
);

  logic sclk_fall, unused_sclk_rise;
  logic ncs_fall, ncs_rise;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (adc_sclk),
    .rise (unused_sclk_rise),
    .fall (sclk_fall)
  );

  // Reset value 0: an ncs already low at release produces no fall.
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ncs (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (adc_ncs),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  logic [SYNC_STAGES-1:0][2:0] addr_sr;
  logic [SYNC_STAGES-1:0]      rng_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sr <= '0;
      rng_sr  <= '0;
    end else begin
      addr_sr <= {addr_sr[SYNC_STAGES-2:0], adc_addr};
      rng_sr  <= {rng_sr[SYNC_STAGES-2:0], adc_rng};
    end
  end

  logic [2:0] addr_s;
  logic       rng_s;
  assign addr_s = addr_sr[SYNC_STAGES-1];
  assign rng_s  = rng_sr[SYNC_STAGES-1];

  logic [DATA_W-1:0] regs_a [N_CH];
  logic [DATA_W-1:0] regs_b [N_CH];

  state_t            state;
  logic [2:0]        ch;
  logic              rng;
  logic [DATA_W-1:0] sa, sb;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  fall_cnt;

  logic              addr_ok, wr_ok;
  logic [DATA_W-1:0] snap_a, snap_b;
  logic [IDX_W-1:0]  nidx;
  logic              go_start, go_end, go_shift;

  assign addr_ok  = addr_s < 3'(N_CH);
  assign wr_ok    = wr_addr < 3'(N_CH);
  assign snap_a   = addr_ok ? regs_a[addr_s] : '0;
  assign snap_b   = addr_ok ? regs_b[addr_s] : '0;
  assign nidx     = bit_idx + 1'b1;
  assign go_start = (state == IDLE) && ncs_fall;
  assign go_end   = (state != IDLE) && ncs_rise;
  assign go_shift = (state == ACTIVE) && sclk_fall && !ncs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        regs_a[i] <= '0;
        regs_b[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      regs_a[wr_addr] <= wr_data_a;
      regs_b[wr_addr] <= wr_data_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch         <= '0;
      rng        <= 1'b0;
      sa         <= '0;
      sb         <= '0;
      bit_idx    <= '0;
      fall_cnt   <= '0;
      adc_a      <= 1'b0;
      adc_b      <= 1'b0;
      adc_oe     <= 1'b0;
      conv_done  <= 1'b0;
      conv_ch    <= '0;
      conv_rng   <= 1'b0;
      conv_count <= '0;
      addr_err   <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      if (go_start && !addr_ok) addr_err <= 1'b1;
      else if (err_clr)         addr_err <= 1'b0;
      unique case (1'b1)
        go_start: begin
          state    <= ACTIVE;
          ch       <= addr_s;
          rng      <= rng_s;
          sa       <= snap_a;
          sb       <= snap_b;
          bit_idx  <= '0;
          fall_cnt <= '0;
          adc_oe   <= 1'b1;
          adc_a    <= slot_bit(snap_a, '0, LEAD_ZEROS);
          adc_b    <= slot_bit(snap_b, '0, LEAD_ZEROS);
        end
        go_end: begin
          state  <= IDLE;
          adc_oe <= 1'b0;
          adc_a  <= 1'b0;
          adc_b  <= 1'b0;
          if (fall_cnt >= CNT_W'(MIN_SCLK_FALLS)) begin
            conv_done  <= 1'b1;
            conv_ch    <= ch;
            conv_rng   <= rng;
            conv_count <= conv_count + 16'd1;
          end
        end
        go_shift: begin
          bit_idx <= nidx;
          if (fall_cnt != '1) fall_cnt <= fall_cnt + 1'b1;
          if (nidx == IDX_W'(FRAME_BITS)) begin
            state <= TRAIL;
            adc_a <= 1'b0;
            adc_b <= 1'b0;
          end else begin
            adc_a <= slot_bit(sa, nidx, LEAD_ZEROS);
            adc_b <= slot_bit(sb, nidx, LEAD_ZEROS);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7265_emu.sv
// Directed bench for ad7265_emu with a per-slot bit scoreboard.
// Expected serial bits are queued at frame start and popped on sampling.
module tb_ad7265_emu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        adc_sclk, adc_ncs, adc_rng;
  logic [2:0]  adc_addr;
  logic        adc_a, adc_b, adc_oe;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data_a, wr_data_b;
  logic        conv_done, conv_rng, addr_err, err_clr;
  logic [2:0]  conv_ch;
  logic [15:0] conv_count;

  int checks = 0;
  int errors = 0;
  logic qa[$];
  logic qb[$];

  always #5 clk = ~clk;

  ad7265_emu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_sclk  (adc_sclk),
    .adc_ncs   (adc_ncs),
    .adc_addr  (adc_addr),
    .adc_rng   (adc_rng),
    .adc_a     (adc_a),
    .adc_b     (adc_b),
    .adc_oe    (adc_oe),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b),
    .conv_done (conv_done),
    .conv_ch   (conv_ch),
    .conv_rng  (conv_rng),
    .conv_count(conv_count),
    .addr_err  (addr_err),
    .err_clr   (err_clr)
  );

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame word: two lead zeros, 12 data bits MSB first, two tail zeros.
  function automatic logic exp_bit(input logic [11:0] d, input int k);
    logic [15:0] w;
    w = {2'b00, d, 2'b00};
    w = w << k;
    if (k < 16) return w[15];
    return 1'b0;
  endfunction

  task automatic write(input logic [2:0] a, input logic [11:0] da,
                       input logic [11:0] db);
    wr_addr = a; wr_data_a = da; wr_data_b = db; wr_en = 1'b1;
    wclk(1);
    wr_en = 1'b0;
  endtask

  task automatic pop_check();
    check("slot_a", 16'(adc_a), 16'(qa.pop_front()));
    check("slot_b", 16'(adc_b), 16'(qb.pop_front()));
  endtask

  task automatic run_frame(input logic [2:0] addr, input logic rng,
                           input int falls, input logic [11:0] da,
                           input logic [11:0] db, input logic fall_wr,
                           input logic fall_clr, output int dones);
    for (int k = 0; k <= falls; k++) begin
      qa.push_back(exp_bit(da, k));
      qb.push_back(exp_bit(db, k));
    end
    adc_addr = addr; adc_rng = rng;
    wclk(3);
    adc_ncs = 1'b0;
    wclk(2);
    wr_en = fall_wr; err_clr = fall_clr;
    wclk(1);
    wr_en = 1'b0; err_clr = 1'b0;
    wclk(3);
    check("oe_active", 16'(adc_oe), 16'd1);
    pop_check();
    for (int i = 1; i <= falls; i++) begin
      adc_sclk = 1'b0;
      wclk(5);
      pop_check();
      adc_sclk = 1'b1;
      wclk(5);
    end
    adc_ncs = 1'b1;
    dones = 0;
    for (int j = 0; j < 8; j++) begin
      wclk(1);
      dones += int'(conv_done);
      if (j == 3) check("oe_off", 16'(adc_oe), 16'd0);
    end
  endtask

  initial begin
    int d;
    logic [15:0] exp_cnt;
    rst_n = 1'b0; adc_sclk = 1'b1; adc_ncs = 1'b1; adc_addr = '0;
    adc_rng = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data_a = '0;
    wr_data_b = '0; err_clr = 1'b0;
    exp_cnt = 16'd0;
    wclk(3);
    check("rst_a", 16'(adc_a), 16'd0);
    check("rst_oe", 16'(adc_oe), 16'd0);
    check("rst_done", 16'(conv_done), 16'd0);
    check("rst_cnt", conv_count, 16'd0);
    check("rst_err", 16'(addr_err), 16'd0);
    rst_n = 1'b1;
    wclk(3);

    write(3'd2, 12'hA5C, 12'h3F1);
    run_frame(3'd2, 1'b1, 16, 12'hA5C, 12'h3F1, 1'b0, 1'b0, d);
    exp_cnt++;
    check("f1_done", 16'(d), 16'd1);
    check("f1_ch", 16'(conv_ch), 16'd2);
    check("f1_rng", 16'(conv_rng), 16'd1);
    check("f1_cnt", conv_count, exp_cnt);

    run_frame(3'd2, 1'b0, 10, 12'hA5C, 12'h3F1, 1'b0, 1'b0, d);
    check("abort_done", 16'(d), 16'd0);
    check("abort_cnt", conv_count, exp_cnt);
    check("abort_rng", 16'(conv_rng), 16'd1);
    run_frame(3'd2, 1'b0, 16, 12'hA5C, 12'h3F1, 1'b0, 1'b0, d);
    exp_cnt++;
    check("f2_done", 16'(d), 16'd1);
    check("f2_cnt", conv_count, exp_cnt);

    run_frame(3'd7, 1'b0, 16, 12'h000, 12'h000, 1'b0, 1'b0, d);
    exp_cnt++;
    check("bad_err", 16'(addr_err), 16'd1);
    check("bad_ch", 16'(conv_ch), 16'd7);
    wclk(20);
    check("err_sticky", 16'(addr_err), 16'd1);
    err_clr = 1'b1;
    wclk(1);
    err_clr = 1'b0;
    check("err_clr", 16'(addr_err), 16'd0);
    run_frame(3'd7, 1'b0, 14, 12'h000, 12'h000, 1'b0, 1'b1, d);
    exp_cnt++;
    check("err_setwins", 16'(addr_err), 16'd1);
    check("min14_done", 16'(d), 16'd1);
    run_frame(3'd6, 1'b0, 13, 12'h000, 12'h000, 1'b0, 1'b0, d);
    check("min13_done", 16'(d), 16'd0);
    check("min13_cnt", conv_count, exp_cnt);

    write(3'd0, 12'h001, 12'h800);
    wr_addr = 3'd0; wr_data_a = 12'hFFF; wr_data_b = 12'h7FE;
    run_frame(3'd0, 1'b0, 16, 12'h001, 12'h800, 1'b1, 1'b0, d);
    exp_cnt++;
    run_frame(3'd0, 1'b0, 16, 12'hFFF, 12'h7FE, 1'b0, 1'b0, d);
    exp_cnt++;
    check("wr_cnt", conv_count, exp_cnt);

    write(3'd6, 12'h123, 12'h456);
    run_frame(3'd0, 1'b0, 16, 12'hFFF, 12'h7FE, 1'b0, 1'b0, d);
    exp_cnt++;

    adc_addr = 3'd2;
    wclk(3);
    adc_ncs = 1'b0;
    wclk(6);
    for (int i = 1; i <= 7; i++) begin
      adc_sclk = 1'b0;
      wclk(5);
      if (i < 7) begin
        adc_sclk = 1'b1;
        wclk(5);
      end
    end
    check("slot7_a", 16'(adc_a), 16'(exp_bit(12'hA5C, 7)));
    check("slot7_b", 16'(adc_b), 16'(exp_bit(12'h3F1, 7)));
    rst_n = 1'b0;
    #1;
    check("mrst_a", 16'(adc_a), 16'd0);
    check("mrst_oe", 16'(adc_oe), 16'd0);
    check("mrst_cnt", conv_count, 16'd0);
    wclk(2);
    rst_n = 1'b1;
    adc_sclk = 1'b1;
    wclk(5);
    for (int i = 0; i < 4; i++) begin
      adc_sclk = 1'b0;
      wclk(5);
      check("quiet_oe", 16'(adc_oe), 16'd0);
      check("quiet_a", 16'(adc_a), 16'd0);
      adc_sclk = 1'b1;
      wclk(5);
    end
    adc_ncs = 1'b1;
    wclk(6);
    run_frame(3'd2, 1'b0, 16, 12'h000, 12'h000, 1'b0, 1'b0, d);
    check("post_rst_done", 16'(d), 16'd1);
    check("post_rst_cnt", conv_count, 16'd1);

    force dut.conv_count = 16'hFFFF;
    wclk(1);
    release dut.conv_count;
    wclk(1);
    run_frame(3'd1, 1'b0, 16, 12'h000, 12'h000, 1'b0, 1'b0, d);
    check("wrap_done", 16'(d), 16'd1);
    check("wrap_cnt", conv_count, 16'd0);

    check("queue_empty", 16'(qa.size() + qb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
